// File: rtl/pool_window_gen_if.sv
// Stream-in / window-out bundle for pool_window_gen.
// The master side is the pixel source; the slave side is the window generator.
interface pool_window_gen_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
);
  localparam int unsigned CW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int unsigned RW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pixel;

  logic              win_valid;
  logic [DATA_W-1:0] pixel1;
  logic [DATA_W-1:0] pixel2;
  logic [DATA_W-1:0] pixel3;
  logic [DATA_W-1:0] pixel4;
  logic [CW-1:0]     win_col;
  logic [RW-1:0]     win_row;
  logic              frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  win_valid, pixel1, pixel2, pixel3, pixel4, win_col, win_row, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output win_valid, pixel1, pixel2, pixel3, pixel4, win_col, win_row, frame_done
  );
endinterface

// File: rtl/pool_window_gen.sv
// Raster-stream to 2x2 non-overlapping window generator feeding avgpool.
// Buffers one even row and emits a window on each odd-row, odd-column beat.
module pool_window_gen #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input logic               clk,
  input logic               rst,
  pool_window_gen_if.slave  bus
);

  localparam int unsigned CW   = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int unsigned RW   = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam int unsigned COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COLW-1:0]   col_q, col_d;
  logic [ROWW-1:0]   row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] linebuf_q [IMG_W];

  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] pixel1_q, pixel1_d;
  logic [DATA_W-1:0] pixel2_q, pixel2_d;
  logic [DATA_W-1:0] pixel3_q, pixel3_d;
  logic [DATA_W-1:0] pixel4_q, pixel4_d;
  logic [CW-1:0]     win_col_q, win_col_d;
  logic [RW-1:0]     win_row_q, win_row_d;

  logic [COLW-1:0]   eff_col_c;
  logic [ROWW-1:0]   eff_row_c;
  logic [COLW-1:0]   left_col_c;
  logic              col_last_c;
  logic              row_last_c;
  logic              fire_c;
  logic              lb_we_c;

  // A start-of-frame beat is position (0,0) regardless of the running counters.
  always_comb begin
    eff_col_c  = bus.in_sof ? '0 : col_q;
    eff_row_c  = bus.in_sof ? '0 : row_q;
    left_col_c = eff_col_c & ~COLW'(1);
    col_last_c = (eff_col_c == COLW'(IMG_W - 1));
    row_last_c = (eff_row_c == ROWW'(IMG_H - 1));
    fire_c     = bus.in_valid & eff_row_c[0] & eff_col_c[0];
    lb_we_c    = bus.in_valid & ~eff_row_c[0];
  end

  // Next-state: raster counters, bottom-left holding register, window outputs.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pixel1_d     = pixel1_q;
    pixel2_d     = pixel2_q;
    pixel3_d     = pixel3_q;
    pixel4_d     = pixel4_q;
    win_col_d    = win_col_q;
    win_row_d    = win_row_q;

    if (bus.in_valid) begin
      if (col_last_c) begin
        col_d = '0;
        row_d = row_last_c ? '0 : eff_row_c + ROWW'(1);
      end else begin
        col_d = eff_col_c + COLW'(1);
        row_d = eff_row_c;
      end

      if (eff_row_c[0] && !eff_col_c[0]) begin
        hold_d = bus.in_pixel;
      end
    end

    if (fire_c) begin
      win_valid_d  = 1'b1;
      frame_done_d = col_last_c & row_last_c;
      pixel1_d     = linebuf_q[left_col_c];
      pixel2_d     = linebuf_q[eff_col_c];
      pixel3_d     = hold_q;
      pixel4_d     = bus.in_pixel;
      win_col_d    = CW'(eff_col_c >> 1);
      win_row_d    = RW'(eff_row_c >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pixel1_q     <= '0;
      pixel2_q     <= '0;
      pixel3_q     <= '0;
      pixel4_q     <= '0;
      win_col_q    <= '0;
      win_row_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      pixel1_q     <= pixel1_d;
      pixel2_q     <= pixel2_d;
      pixel3_q     <= pixel3_d;
      pixel4_q     <= pixel4_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
    end
  end

  // Line buffer holds data only; its contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (lb_we_c) begin
      linebuf_q[eff_col_c] <= bus.in_pixel;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pixel1     = pixel1_q;
  assign bus.pixel2     = pixel2_q;
  assign bus.pixel3     = pixel3_q;
  assign bus.pixel4     = pixel4_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x2 and a 4x4 instance checked against a
// frame-array reference model, a directed vector table and corner sequences.
module tb_pool_window_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_window_gen_if #(.DATA_W(4), .IMG_W(4), .IMG_H(2)) ifa ();
  pool_window_gen_if #(.DATA_W(4), .IMG_W(4), .IMG_H(4)) ifb ();

  pool_window_gen #(.DATA_W(4), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pool_window_gen #(.DATA_W(4), .IMG_W(4), .IMG_H(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // {valid, p1, p2, p3, p4, col, row, done}
  typedef struct {
    logic       s;
    logic [3:0] px;
    logic       v;
    logic [3:0] p1, p2, p3, p4;
    logic [3:0] c, r;
    logic       d;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pos    [2];
  logic [3:0]  img    [2][4][4];
  logic [25:0] exp_o  [2];
  int          wd     [2] = '{4, 4};
  int          ht     [2] = '{2, 4};
  int          pulses [2] = '{0, 0};
  string       tag = "init";
  vec_t        tbl [8];

  task automatic cmp(input string name, input logic [25:0] act, input logic [25:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [25:0] dut_vec(input int id);
    if (id == 0)
      return {ifa.win_valid, ifa.pixel1, ifa.pixel2, ifa.pixel3, ifa.pixel4,
              4'(ifa.win_col), 4'(ifa.win_row), ifa.frame_done};
    return {ifb.win_valid, ifb.pixel1, ifb.pixel2, ifb.pixel3, ifb.pixel4,
            4'(ifb.win_col), 4'(ifb.win_row), ifb.frame_done};
  endfunction

  // Frame-array model: linear position within frame gives (row, col).
  function automatic void model_step(input int id, input logic v, input logic s,
                                     input logic [3:0] px);
    int r;
    int c;
    exp_o[id][25] = 1'b0;
    exp_o[id][0]  = 1'b0;
    if (v) begin
      if (s) pos[id] = 0;
      r = pos[id] / wd[id];
      c = pos[id] % wd[id];
      img[id][r][c] = px;
      if ((r % 2 == 1) && (c % 2 == 1))
        exp_o[id] = {1'b1, img[id][r-1][c-1], img[id][r-1][c], img[id][r][c-1], px,
                     4'(c / 2), 4'(r / 2), 1'((r == ht[id] - 1) && (c == wd[id] - 1))};
      pos[id] = (pos[id] + 1) % (wd[id] * ht[id]);
    end
  endfunction

  task automatic drive(input int id, input logic v, input logic s, input logic [3:0] px);
    ifa.in_valid = 1'b0; ifa.in_sof = 1'b0; ifa.in_pixel = '0;
    ifb.in_valid = 1'b0; ifb.in_sof = 1'b0; ifb.in_pixel = '0;
    if (id == 0) begin
      ifa.in_valid = v; ifa.in_sof = s; ifa.in_pixel = px;
    end else begin
      ifb.in_valid = v; ifb.in_sof = s; ifb.in_pixel = px;
    end
  endtask

  // One clock: drive, update model at the edge, check both instances at negedge.
  task automatic cycle(input int id, input logic v, input logic s, input logic [3:0] px);
    drive(id, v, s, px);
    @(posedge clk);
    model_step(0, (id == 0) && v, s, px);
    model_step(1, (id == 1) && v, s, px);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [25:0] got;
      got = dut_vec(k);
      if (got[25]) pulses[k]++;
      cmp($sformatf("%s dut%0d", tag, k), got, exp_o[k]);
    end
    drive(id, 1'b0, 1'b0, 4'h0);
  endtask

  function automatic vec_t mk(input logic s, input logic [3:0] px, input logic v,
                              input logic [3:0] p1, input logic [3:0] p2,
                              input logic [3:0] p3, input logic [3:0] p4,
                              input logic [3:0] c, input logic [3:0] r, input logic d);
    vec_t t;
    t.s = s; t.px = px; t.v = v;
    t.p1 = p1; t.p2 = p2; t.p3 = p3; t.p4 = p4;
    t.c = c; t.r = r; t.d = d;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    tbl[0] = mk(1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tbl[1] = mk(1'b0, 4'd2, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tbl[2] = mk(1'b0, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tbl[3] = mk(1'b0, 4'd4, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tbl[4] = mk(1'b0, 4'd5, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tbl[5] = mk(1'b0, 4'd6, 1'b1, 4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd0, 1'b0);
    tbl[6] = mk(1'b0, 4'd7, 1'b0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd0, 1'b0);
    tbl[7] = mk(1'b0, 4'd8, 1'b1, 4'd3, 4'd4, 4'd7, 4'd8, 4'd1, 4'd0, 1'b1);

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      pos[k]   = 0;
      exp_o[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("reset dut0", dut_vec(0), 26'h0);
    cmp("reset dut1", dut_vec(1), 26'h0);

    // Directed 4x2 frame from the vector table.
    tag = "table";
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'b1, tbl[i].s, tbl[i].px);
      cmp($sformatf("table beat%0d", i + 1), dut_vec(0),
          {tbl[i].v, tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].p4, tbl[i].c, tbl[i].r, tbl[i].d});
    end
    cmp_int("table pulse count", pulses[0], 2);

    // Same frame with random idle gaps.
    tag = "gaps";
    p0 = pulses[0];
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) cycle(0, 1'b0, 1'b0, 4'h0);
      cycle(0, 1'b1, 1'(i == 0), 4'(i + 1));
    end
    repeat (2) cycle(0, 1'b0, 1'b0, 4'h0);
    cmp_int("gaps pulse count", pulses[0] - p0, 2);

    // Two back-to-back 4x4 frames, second without in_sof.
    tag = "4x4";
    p0 = pulses[1];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        cycle(1, 1'b1, 1'((f == 0) && (i == 0)), 4'(i));
        if (i == 15)
          cmp($sformatf("4x4 window11 frame%0d", f), dut_vec(1),
              {1'b1, 4'd10, 4'd11, 4'd14, 4'd15, 4'd1, 4'd1, 1'b1});
      end
    end
    cmp_int("4x4 pulse count", pulses[1] - p0, 8);

    // Checkerboard of all-ones / all-zeros pixels.
    tag = "extreme";
    for (int i = 0; i < 16; i++)
      cycle(1, 1'b1, 1'(i == 0), ((i + i / 4) % 2 == 1) ? 4'hF : 4'h0);

    // in_sof on beat 6 abandons the partial frame.
    tag = "midsof";
    p0 = pulses[0];
    for (int i = 0; i < 5; i++) cycle(0, 1'b1, 1'(i == 0), 4'($urandom));
    for (int i = 0; i < 8; i++) cycle(0, 1'b1, 1'(i == 0), 4'($urandom));
    cmp_int("midsof pulse count", pulses[0] - p0, 2);

    // Randomised traffic on both instances with occasional in_sof.
    tag = "random";
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 1), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0), 4'($urandom));

    // Asynchronous reset while a window pulse is visible.
    tag = "prerst";
    for (int i = 0; i < 6; i++) cycle(1, 1'b1, 1'(i == 0), 4'($urandom));
    cmp("prerst pulse visible", {25'h0, ifb.win_valid}, 26'h1);
    #1 rst = 1'b1;
    #1;
    cmp("async reset dut0", dut_vec(0), 26'h0);
    cmp("async reset dut1", dut_vec(1), 26'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pos[k]   = 0;
      exp_o[k] = '0;
    end

    tag = "postrst";
    p0 = pulses[1];
    for (int i = 0; i < 16; i++) cycle(1, 1'b1, 1'b0, 4'($urandom));
    for (int i = 0; i < 8; i++) cycle(0, 1'b1, 1'b0, 4'($urandom));
    cmp_int("postrst pulse count", pulses[1] - p0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
